quant_pack_out: RTL and testbench
=================================

// Module: quant_pack_out
// PURPOSE
//  Downstream neighbour of the row result serializer. Consumes one serialized
//  32b PE accumulator plus its activation sum per valid cycle and requantizes
//  it to int8: weight zero-point correction, bias, Q31 multiply, rounding
//  shift, output zero point, clamp. Packs 8 results into one 64b word for the
//  output buffer write port. No backpressure; accepts one input per cycle.
// PARAMETERS
//  QOUT_BITS  32  width of serial_result / serial_actresult (signed)
//  OUT_BITS   8   quantized output width (signed)
//  PACK_NUM   8   results per packed word (power of 2)
//  SHIFT_BITS 6   width of cfg_shift
// PORTS
//  clk               in   1                    clock
//  reset             in   1                    sync active-high reset
//  valid_in          in   1                    input beat valid (from serializer valid_out)
//  serial_result     in   QOUT_BITS            signed accumulator
//  serial_actresult  in   QOUT_BITS            signed activation sum of same PE
//  flush             in   1                    1-cycle pulse: emit partial word after drain
//  cfg_wzp           in   8                    signed weight zero point
//  cfg_bias          in   32                   signed bias
//  cfg_mult          in   32                   signed Q31 multiplier M0
//  cfg_shift         in   SHIFT_BITS           right shift 0..31 (values >31 treated as 31)
//  cfg_ozp           in   8                    signed output zero point
//  pk_valid          out  1                    1-cycle pulse: pk_data/pk_be valid
//  pk_data           out  OUT_BITS*PACK_NUM    packed bytes, first result in [7:0]
//  pk_be             out  PACK_NUM             byte enables, bit i -> byte i
//  busy              out  1                    any valid beat in pipe or partial word held
// BEHAVIOUR
//  - Reset: pk_valid=0, pk_data=0, pk_be=0, busy=0; pipe valids, flush pipe, pack count cleared.
//  - cfg_* sampled live; must be stable whenever busy=1 or valid_in=1.
//  - S1 (edge t+1): corr = acc - wzp*actsum + bias, 48b signed, saturate to int32.
//  - S2 (edge t+2): prod = corr * cfg_mult, full 64b signed.
//  - S3 (edge t+3): tot = 31+shift; r = (prod + 2^(tot-1)) >>> tot (round half up);
//    q = r + ozp in 34b signed; clamp to [-128,127].
//  - Packer (edge t+4): byte written to slot cnt, be bit set, cnt++ (mod PACK_NUM).
//    When slot PACK_NUM-1 written: pk_valid=1, pk_be=all ones; slot/be cleared same edge.
//  - Latency: valid_in at t -> completing word's pk_valid high in cycle after edge t+4.
//  - flush travels a 3-stage delay beside data; at S3 output: if same-cycle byte
//    valid it is packed first; then if cnt>0 (incl. that byte) emit word with
//    pk_be = written slots, unwritten bytes 0, cnt reset. Flush with cnt=0 and no
//    byte: no pk_valid. Flush coinciding with 8th byte: one full word only.
//  - Back-to-back valid_in every cycle: full throughput, one word per 8 beats.
//  - valid_in=0 beats ignored; data fields don't-care.
//  - Reset mid-operation: all in-flight beats and partial word discarded, no output.
//  - busy = |S1..S3 valid | |flush pipe | (cnt!=0).
// STRUCTURE
//  - Shared package: OUT_BITS/PACK_NUM defaults, Q31 constant 31, INT8 min/max
//    constants, requant cfg struct typedef.
//  - Sub-module: requant_core (S1..S3 arithmetic, valid+flush pipe); top keeps packer.
// TESTING
//  - wzp=2,bias=20,mult=0x40000000,shift=1,ozp=-3; acc=100,actsum=10 -> byte 22 (0x16).
//  - Rounding: mult=0x40000000,shift=0,ozp=0,wzp=0,bias=0; acc=3 -> 2; acc=-3 -> -1.
//  - Clamp: acc=1000 (same cfg as #1) -> 127; acc=-1000 -> -128; corr saturates at int32.
//  - 8 back-to-back beats acc=0..7 (mult=0x7FFFFFFF,shift=0,ozp=0) -> one pk_valid,
//    pk_data=0x0706050403020100 (±1 LSB per byte from M0<1), pk_be=0xFF, 4 cycles after last.
//  - 3 beats then flush -> pk_valid with pk_be=0x07, bytes 3..7 zero; flush idle -> none.
//  - Reset asserted after 5 beats -> no pk_valid, busy=0; next 8 beats pack from slot 0.

Source files
------------

// File: rtl/quant_pack_out_pkg.sv
// ============================================================================
// quant_pack_out_pkg : shared widths, int8 limits and requant config record
// Rev 1.0
// ============================================================================
`default_nettype none

package quant_pack_out_pkg;

   localparam int QOUT_BITS_DEF  = 32;
   localparam int OUT_BITS_DEF   = 8;
   localparam int PACK_NUM_DEF   = 8;
   localparam int SHIFT_BITS_DEF = 6;

   localparam int Q31_FRAC   = 31;
   localparam int INT8_MIN   = -128;
   localparam int INT8_MAX   = 127;
   localparam int CORR_BITS  = 48;
   localparam int PROD_BITS  = 64;
   localparam int ROUND_BITS = 34;
   localparam int EFF_SHIFT_BITS = 5;

   // Shift is stored already clamped to 0..31 so the core never sees >31.
   typedef struct packed {
      logic [7:0]                wzp;
      logic [31:0]               bias;
      logic [31:0]               mult;
      logic [EFF_SHIFT_BITS-1:0] shift;
      logic [7:0]                ozp;
   } requant_cfg_t;

endpackage

`default_nettype wire

// File: rtl/quant_pack_out_requant.sv
// ============================================================================
// requant_core : three-stage int32 -> int8 requantization with valid/flush pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module requant_core
   import quant_pack_out_pkg::*;
#(
   parameter int QOUT_BITS = QOUT_BITS_DEF,
   parameter int OUT_BITS  = OUT_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   input  logic [QOUT_BITS-1:0] acc,
   input  logic [QOUT_BITS-1:0] actsum,
   input  logic                 flush,
   input  requant_cfg_t         cfg,
   output logic                 out_valid,
   output logic [OUT_BITS-1:0]  out_byte,
   output logic                 out_flush,
   output logic                 busy
);

   localparam logic signed [CORR_BITS-1:0]  C_SAT_MAX = 48'sh0000_7FFF_FFFF;
   localparam logic signed [CORR_BITS-1:0]  C_SAT_MIN = 48'shFFFF_8000_0000;
   localparam logic signed [ROUND_BITS-1:0] Q_MAX     = ROUND_BITS'(INT8_MAX);
   localparam logic signed [ROUND_BITS-1:0] Q_MIN     = ROUND_BITS'(INT8_MIN);

   logic                 v1, v2, v3;
   logic                 f1, f2, f3;
   logic signed [31:0]   corr_r;
   logic signed [PROD_BITS-1:0] prod_r;
   logic [OUT_BITS-1:0]  byte_r;

   logic signed [CORR_BITS-1:0] acc_x, act_x, wzp_x, bias_x, corr_full;
   logic signed [31:0]          corr_sat;

   always_comb begin
      acc_x     = {{(CORR_BITS-QOUT_BITS){acc[QOUT_BITS-1]}}, acc};
      act_x     = {{(CORR_BITS-QOUT_BITS){actsum[QOUT_BITS-1]}}, actsum};
      wzp_x     = {{(CORR_BITS-8){cfg.wzp[7]}}, cfg.wzp};
      bias_x    = {{(CORR_BITS-32){cfg.bias[31]}}, cfg.bias};
      corr_full = acc_x - wzp_x * act_x + bias_x;
      if (corr_full > C_SAT_MAX) begin
         corr_sat = 32'sh7FFF_FFFF;
      end else if (corr_full < C_SAT_MIN) begin
         corr_sat = 32'sh8000_0000;
      end else begin
         corr_sat = corr_full[31:0];
      end
   end

   logic signed [PROD_BITS-1:0] corr_x, mult_x, prod_next;

   always_comb begin
      corr_x    = {{(PROD_BITS-32){corr_r[31]}}, corr_r};
      mult_x    = {{(PROD_BITS-32){cfg.mult[31]}}, cfg.mult};
      prod_next = corr_x * mult_x;
   end

   // Round half up: add 2^(tot-1) then arithmetic shift; r fits in 33 bits.
   logic [5:0]                   tot;
   logic signed [PROD_BITS-1:0]  rnd, sum_r, shifted;
   logic signed [ROUND_BITS-1:0] r34, q34;
   logic [OUT_BITS-1:0]          byte_next;

   always_comb begin
      tot     = 6'(Q31_FRAC) + {1'b0, cfg.shift};
      rnd     = 64'sd1 <<< (tot - 6'd1);
      sum_r   = prod_r + rnd;
      shifted = sum_r >>> tot;
      r34     = shifted[ROUND_BITS-1:0];
      q34     = r34 + {{(ROUND_BITS-8){cfg.ozp[7]}}, cfg.ozp};
      if (q34 > Q_MAX) begin
         byte_next = Q_MAX[OUT_BITS-1:0];
      end else if (q34 < Q_MIN) begin
         byte_next = Q_MIN[OUT_BITS-1:0];
      end else begin
         byte_next = q34[OUT_BITS-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         v3     <= 1'b0;
         f1     <= 1'b0;
         f2     <= 1'b0;
         f3     <= 1'b0;
         corr_r <= '0;
         prod_r <= '0;
         byte_r <= '0;
      end else begin
         v1     <= valid_in;
         v2     <= v1;
         v3     <= v2;
         f1     <= flush;
         f2     <= f1;
         f3     <= f2;
         corr_r <= corr_sat;
         prod_r <= prod_next;
         byte_r <= byte_next;
      end
   end

   assign out_valid = v3;
   assign out_byte  = byte_r;
   assign out_flush = f3;
   assign busy      = v1 | v2 | v3 | f1 | f2 | f3;

endmodule

`default_nettype wire

// File: rtl/quant_pack_out.sv
// ============================================================================
// quant_pack_out : requantizes serialized accumulators and packs int8 words
// Rev 1.0
// ============================================================================
`default_nettype none

module quant_pack_out
   import quant_pack_out_pkg::*;
#(
   parameter int QOUT_BITS  = QOUT_BITS_DEF,
   parameter int OUT_BITS   = OUT_BITS_DEF,
   parameter int PACK_NUM   = PACK_NUM_DEF,
   parameter int SHIFT_BITS = SHIFT_BITS_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_in,
   input  logic [QOUT_BITS-1:0]         serial_result,
   input  logic [QOUT_BITS-1:0]         serial_actresult,
   input  logic                         flush,
   input  logic [7:0]                   cfg_wzp,
   input  logic [31:0]                  cfg_bias,
   input  logic [31:0]                  cfg_mult,
   input  logic [SHIFT_BITS-1:0]        cfg_shift,
   input  logic [7:0]                   cfg_ozp,
   output logic                         pk_valid,
   output logic [OUT_BITS*PACK_NUM-1:0] pk_data,
   output logic [PACK_NUM-1:0]          pk_be,
   output logic                         busy
);

   localparam int CNT_BITS  = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
   localparam int WORD_BITS = OUT_BITS * PACK_NUM;

   requant_cfg_t cfg;

   always_comb begin
      cfg.wzp   = cfg_wzp;
      cfg.bias  = cfg_bias;
      cfg.mult  = cfg_mult;
      cfg.ozp   = cfg_ozp;
      cfg.shift = (cfg_shift > SHIFT_BITS'(31)) ? 5'd31 : cfg_shift[EFF_SHIFT_BITS-1:0];
   end

   logic                core_valid;
   logic [OUT_BITS-1:0] core_byte;
   logic                core_flush;
   logic                core_busy;

   requant_core #(
      .QOUT_BITS (QOUT_BITS),
      .OUT_BITS  (OUT_BITS)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .acc       (serial_result),
      .actsum    (serial_actresult),
      .flush     (flush),
      .cfg       (cfg),
      .out_valid (core_valid),
      .out_byte  (core_byte),
      .out_flush (core_flush),
      .busy      (core_busy)
   );

   logic [CNT_BITS-1:0]  cnt;
   logic [WORD_BITS-1:0] acc_data;
   logic [PACK_NUM-1:0]  acc_be;

   logic [WORD_BITS-1:0] next_data;
   logic [PACK_NUM-1:0]  next_be;
   logic                 word_full;
   logic                 emit;

   // A same-cycle byte is merged before the flush decision.
   always_comb begin
      next_data = acc_data;
      next_be   = acc_be;
      if (core_valid) begin
         next_data[cnt*OUT_BITS +: OUT_BITS] = core_byte;
         next_be[cnt]                        = 1'b1;
      end
      word_full = core_valid && (cnt == CNT_BITS'(PACK_NUM-1));
      emit      = word_full || (core_flush && (core_valid || (cnt != '0)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         acc_data <= '0;
         acc_be   <= '0;
         pk_valid <= 1'b0;
         pk_data  <= '0;
         pk_be    <= '0;
      end else begin
         pk_valid <= emit;
         if (emit) begin
            pk_data  <= next_data;
            pk_be    <= next_be;
            cnt      <= '0;
            acc_data <= '0;
            acc_be   <= '0;
         end else begin
            acc_data <= next_data;
            acc_be   <= next_be;
            if (core_valid) begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign busy = core_busy | (cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_quant_pack_out.sv
// ============================================================================
// tb_quant_pack_out : table vectors plus scoreboarded multi-beat sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_quant_pack_out;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] serial_result;
   logic [31:0] serial_actresult;
   logic        flush;
   logic [7:0]  cfg_wzp;
   logic [31:0] cfg_bias;
   logic [31:0] cfg_mult;
   logic [5:0]  cfg_shift;
   logic [7:0]  cfg_ozp;
   logic        pk_valid;
   logic [63:0] pk_data;
   logic [7:0]  pk_be;
   logic        busy;

   always #5 clk = ~clk;

   quant_pack_out dut (
      .clk              (clk),
      .reset            (reset),
      .valid_in         (valid_in),
      .serial_result    (serial_result),
      .serial_actresult (serial_actresult),
      .flush            (flush),
      .cfg_wzp          (cfg_wzp),
      .cfg_bias         (cfg_bias),
      .cfg_mult         (cfg_mult),
      .cfg_shift        (cfg_shift),
      .cfg_ozp          (cfg_ozp),
      .pk_valid         (pk_valid),
      .pk_data          (pk_data),
      .pk_be            (pk_be),
      .busy             (busy)
   );

   typedef struct {
      logic [7:0]  wzp;
      logic [31:0] bias;
      logic [31:0] mult;
      logic [5:0]  shift;
      logic [7:0]  ozp;
      logic [31:0] acc;
      logic [31:0] act;
      logic [7:0]  exp_byte;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  be;
      int          cyc;
   } exp_t;

   vec_t tbl[11];
   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   int          m_cnt = 0;
   logic [63:0] m_data = '0;
   logic [7:0]  m_be = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] model(input logic [7:0] wzp, input logic [31:0] bias,
                                        input logic [31:0] mult, input logic [5:0] sh,
                                        input logic [7:0] ozp, input logic [31:0] a,
                                        input logic [31:0] act);
      longint c, p, r, q;
      int     s;
      c = longint'($signed(a)) - longint'($signed(wzp)) * longint'($signed(act))
          + longint'($signed(bias));
      if (c > 64'sd2147483647) c = 64'sd2147483647;
      else if (c < -64'sd2147483648) c = -64'sd2147483648;
      s = (sh > 6'd31) ? 31 : int'(sh);
      p = c * longint'($signed(mult));
      r = (p + (longint'(1) <<< (30 + s))) >>> (31 + s);
      q = r + longint'($signed(ozp));
      if (q > 127) q = 127;
      else if (q < -128) q = -128;
      return 8'(q);
   endfunction

   task automatic model_pack(input logic v, input logic [7:0] b, input logic f);
      if (v) begin
         m_data[m_cnt*8 +: 8] = b;
         m_be[m_cnt] = 1'b1;
         m_cnt++;
      end
      if (m_cnt == 8 || (f && m_cnt > 0)) begin
         sb.push_back('{m_data, m_be, cyc + 4});
         m_cnt  = 0;
         m_data = '0;
         m_be   = '0;
      end
   endtask

   task automatic beat(input logic v, input logic [31:0] a, input logic [31:0] act,
                       input logic f);
      model_pack(v, model(cfg_wzp, cfg_bias, cfg_mult, cfg_shift, cfg_ozp, a, act), f);
      valid_in         = v;
      serial_result    = a;
      serial_actresult = act;
      flush            = f;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic set_cfg(input logic [7:0] w, input logic [31:0] b, input logic [31:0] m,
                          input logic [5:0] s, input logic [7:0] o);
      cfg_wzp = w; cfg_bias = b; cfg_mult = m; cfg_shift = s; cfg_ozp = o;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Output monitor: every pk_valid must match the oldest expected word on time.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         n_vec++;
         n_err++;
         $display("FAIL missing_word: no pk_valid at cycle %0d, expected data=%h be=%h",
                  sb[0].cyc, sb[0].data, sb[0].be);
         void'(sb.pop_front());
      end
      if (pk_valid) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word: data=%h be=%h at cycle %0d, expected none",
                     pk_data, pk_be, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (pk_data !== e.data || pk_be !== e.be || cyc != e.cyc) begin
               n_err++;
               $display("FAIL word: got data=%h be=%h cyc=%0d expected data=%h be=%h cyc=%0d",
                        pk_data, pk_be, cyc, e.data, e.be, e.cyc);
            end
         end
      end
   end

   initial begin
      tbl[0]  = '{8'h02, 32'd20,        32'h4000_0000, 6'd1,  8'hFD, 32'd100,       32'd10,        8'h16};
      tbl[1]  = '{8'h00, 32'd0,         32'h4000_0000, 6'd0,  8'h00, 32'd3,         32'd0,         8'h02};
      tbl[2]  = '{8'h00, 32'd0,         32'h4000_0000, 6'd0,  8'h00, 32'hFFFF_FFFD, 32'd0,         8'hFF};
      tbl[3]  = '{8'h02, 32'd20,        32'h4000_0000, 6'd1,  8'hFD, 32'd1000,      32'd10,        8'h7F};
      tbl[4]  = '{8'h02, 32'd20,        32'h4000_0000, 6'd1,  8'hFD, 32'hFFFF_FC18, 32'd10,        8'h80};
      tbl[5]  = '{8'h02, 32'd20,        32'h4000_0000, 6'd30, 8'h00, 32'h7FFF_FFFF, 32'hFFFF_FFF6, 8'h01};
      tbl[6]  = '{8'h02, 32'hFFFF_FFEC, 32'h4000_0000, 6'd30, 8'h00, 32'h8000_0000, 32'd10,        8'hFF};
      tbl[7]  = '{8'h00, 32'd0,         32'h4000_0000, 6'd40, 8'h05, 32'h7FFF_FFFF, 32'd0,         8'h05};
      tbl[8]  = '{8'h00, 32'd0,         32'h4000_0000, 6'd0,  8'h7F, 32'd2,         32'd0,         8'h7F};
      tbl[9]  = '{8'h00, 32'd0,         32'h4000_0000, 6'd0,  8'h80, 32'hFFFF_FFFE, 32'd0,         8'h80};
      tbl[10] = '{8'h00, 32'd0,         32'hC000_0000, 6'd0,  8'h00, 32'd5,         32'd0,         8'hFE};

      reset = 1'b1;
      valid_in = 1'b0; serial_result = '0; serial_actresult = '0; flush = 1'b0;
      set_cfg(8'h00, 32'h0, 32'h0, 6'd0, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pk_valid", 64'(pk_valid), 64'h0);
      chk("reset_pk_data",  pk_data,       64'h0);
      chk("reset_pk_be",    64'(pk_be),    64'h0);
      chk("reset_busy",     64'(busy),     64'h0);
      reset = 1'b0;
      idle(2);

      // Single beats with flush: each yields a one-byte word.
      for (int i = 0; i < 11; i++) begin
         set_cfg(tbl[i].wzp, tbl[i].bias, tbl[i].mult, tbl[i].shift, tbl[i].ozp);
         sb.push_back('{{56'h0, tbl[i].exp_byte}, 8'h01, cyc + 4});
         valid_in = 1'b1; serial_result = tbl[i].acc; serial_actresult = tbl[i].act;
         flush = 1'b1;
         @(posedge clk);
         #1;
         idle(7);
         chk("drained_busy", 64'(busy), 64'h0);
      end

      // Full-throughput word.
      set_cfg(8'h00, 32'h0, 32'h7FFF_FFFF, 6'd0, 8'h00);
      sb.push_back('{64'h0706_0504_0302_0100, 8'hFF, cyc + 11});
      for (int i = 0; i < 8; i++) begin
         valid_in = 1'b1; serial_result = 32'(i); serial_actresult = '0; flush = 1'b0;
         @(posedge clk);
         #1;
      end
      idle(8);

      // Partial word, then a flush on an idle packer.
      set_cfg(8'h02, 32'd20, 32'h4000_0000, 6'd1, 8'hFD);
      beat(1'b1, 32'd100, 32'd10, 1'b0);
      beat(1'b1, 32'd200, 32'd5,  1'b0);
      beat(1'b1, 32'hFFFF_FF38, 32'd3, 1'b0);
      beat(1'b0, 32'h0, 32'h0, 1'b1);
      idle(6);
      beat(1'b0, 32'h0, 32'h0, 1'b1);
      idle(6);

      // Flush coinciding with the eighth byte.
      for (int i = 0; i < 8; i++) beat(1'b1, 32'(i * 37), 32'(i), (i == 7));
      idle(6);

      // Reset in the middle of a partial word.
      for (int i = 0; i < 5; i++) beat(1'b1, 32'(i * 11), 32'd1, 1'b0);
      chk("busy_midstream", 64'(busy), 64'h1);
      reset = 1'b1;
      m_cnt = 0; m_data = '0; m_be = '0;
      @(posedge clk);
      #1;
      chk("busy_after_reset", 64'(busy), 64'h0);
      chk("pk_valid_after_reset", 64'(pk_valid), 64'h0);
      reset = 1'b0;
      idle(6);
      for (int i = 0; i < 8; i++) beat(1'b1, 32'(100 + i * 9), 32'd2, 1'b0);
      idle(6);

      // Random stream: one full word plus a 5-byte tail.
      for (int i = 0; i < 13; i++)
         beat(1'b1, 32'($urandom_range(0, 4000)) - 32'd2000,
              32'($urandom_range(0, 50)), (i == 12));
      idle(8);
      chk("final_busy", 64'(busy), 64'h0);
      chk("scoreboard_empty", 64'(sb.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
